// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths and the next-PC select encoding.
package cpu_pkg;

  localparam int PC_W_DEF        = 8;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    JUMP,
    CALL,
    RET
  } next_pc_sel_e;

  // Occupancy counter must be able to represent DEPTH itself, hence the extra bit.
  function automatic int stack_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the instruction sequencer and the program-counter unit.
interface pc_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic            stall;
  logic            jump_enable;
  logic [PC_W-1:0] jump_addr;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic            stack_empty;
  logic            stack_full;
  logic            stack_err;

  modport master (
    output stall, jump_enable, jump_addr, call, ret,
    input  pc, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  stall, jump_enable, jump_addr, call, ret,
    output pc, stack_empty, stack_full, stack_err
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with registered empty/full flags; it refuses overflow and underflow on its own.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = stack_cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign wr_idx  = count[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign rdata   = mem[rd_idx];
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;

  // NOTE: every signal driven in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    count_nxt = count;
    if (do_push)     count_nxt = count + CW'(1);
    else if (do_pop) count_nxt = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy counter alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack: resolves per-cycle priority and flags illegal stack operations.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stk_rdata;
  logic            stk_empty;
  logic            stk_full;
  logic            push;
  logic            pop;
  logic            err_d;
  logic            err_q;
  next_pc_sel_e    sel;

  assign pc_inc = pc_q + PC_W'(1);

  // Priority: stall > call&ret > ret > call > jump > increment; refused stack ops fall back to INC.
  always_comb begin
    sel   = INC;
    push  = 1'b0;
    pop   = 1'b0;
    err_d = 1'b0;
    if (bus.stall) begin
      sel = HOLD;
    end else if (bus.call && bus.ret) begin
      err_d = 1'b1;
    end else if (bus.ret) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        sel = RET;
        pop = 1'b1;
      end
    end else if (bus.call) begin
      if (stk_full) begin
        err_d = 1'b1;
      end else begin
        sel  = CALL;
        push = 1'b1;
      end
    end else if (bus.jump_enable) begin
      sel = JUMP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (sel)
        HOLD:       pc_q <= pc_q;
        JUMP, CALL: pc_q <= bus.jump_addr;
        RET:        pc_q <= stk_rdata;
        default:    pc_q <= pc_inc;
      endcase
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .rdata (stk_rdata),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign bus.pc          = pc_q;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model checked every cycle, plus literal checkpoints.
module tb_pc_unit;

  localparam int PC_W  = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  pc_unit_if #(.PC_W(PC_W)) bus ();

  pc_unit #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC plus a queue used as the return stack.
  int m_pc    = 0;
  int m_stk[$];
  bit m_err   = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    = 0;
      m_stk.delete();
      m_err   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_err = 0;
      if (bus.stall) begin
        // nothing moves
      end else if (bus.call && bus.ret) begin
        m_err = 1;
        m_pc  = (m_pc + 1) % (1 << PC_W);
      end else if (bus.ret) begin
        if (m_stk.size() == 0) begin
          m_err = 1;
          m_pc  = (m_pc + 1) % (1 << PC_W);
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (bus.call) begin
        if (m_stk.size() == DEPTH) begin
          m_err = 1;
          m_pc  = (m_pc + 1) % (1 << PC_W);
        end else begin
          m_stk.push_back((m_pc + 1) % (1 << PC_W));
          m_pc = int'(bus.jump_addr);
        end
      end else if (bus.jump_enable) begin
        m_pc = int'(bus.jump_addr);
      end else begin
        m_pc = (m_pc + 1) % (1 << PC_W);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pc",    32'(bus.pc),          32'(m_pc));
      check("model_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
      check("model_full",  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
      check("model_err",   32'(bus.stack_err),   32'(m_err));
    end
  end

  task automatic step(input logic rst, input logic st, input logic je,
                      input logic [PC_W-1:0] addr, input logic c, input logic r);
    reset           = rst;
    bus.stall       = st;
    bus.jump_enable = je;
    bus.jump_addr   = addr;
    bus.call        = c;
    bus.ret         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [PC_W-1:0] addr);
    step(1'b0, 1'b0, 1'b1, addr, 1'b0, 1'b0);
  endtask

  task automatic do_call(input logic [PC_W-1:0] addr);
    step(1'b0, 1'b0, 1'b0, addr, 1'b1, 1'b0);
  endtask

  task automatic do_ret();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.jump_enable = 1'b0; bus.jump_addr = '0;
    bus.call = 1'b0; bus.ret = 1'b0;

    // Reset and free-running increment
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_empty", 32'(bus.stack_empty), 32'h1);
    check("rst_full", 32'(bus.stack_full), 32'h0);
    check("rst_err", 32'(bus.stack_err), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("inc_pc", 32'(bus.pc), 32'(i));
    end
    check("inc_empty", 32'(bus.stack_empty), 32'h1);

    // Jump and stall
    jump(8'h10);
    check("jump_pc", 32'(bus.pc), 32'h10);
    step(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
    check("stall_pc", 32'(bus.pc), 32'h10);
    jump(8'h40);
    check("jump2_pc", 32'(bus.pc), 32'h40);

    // Single call/return
    jump(8'h05);
    do_call(8'h80);
    check("call_pc", 32'(bus.pc), 32'h80);
    check("call_empty", 32'(bus.stack_empty), 32'h0);
    do_ret();
    check("ret_pc", 32'(bus.pc), 32'h06);
    check("ret_empty", 32'(bus.stack_empty), 32'h1);

    // Fill the stack, overflow, then unwind
    jump(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      do_call(8'(8'h20 + 8'h10 * i));
      check("nest_pc", 32'(bus.pc), 32'(8'h20 + 8'h10 * i));
    end
    check("nest_full", 32'(bus.stack_full), 32'h1);
    do_call(8'hF0);
    check("ovf_pc", 32'(bus.pc), 32'h91);
    check("ovf_err", 32'(bus.stack_err), 32'h1);
    check("ovf_full", 32'(bus.stack_full), 32'h1);
    idle();
    check("ovf_err_clr", 32'(bus.stack_err), 32'h0);
    check("ovf_next_pc", 32'(bus.pc), 32'h92);
    for (int i = 0; i < DEPTH; i++) begin
      do_ret();
      check("unwind_pc", 32'(bus.pc), (i < DEPTH - 1) ? 32'(8'h81 - 8'h10 * i) : 32'h01);
    end
    check("unwind_empty", 32'(bus.stack_empty), 32'h1);

    // Underflow at the top of the address space, plain wrap
    jump(8'hFF);
    do_ret();
    check("udf_pc", 32'(bus.pc), 32'h00);
    check("udf_err", 32'(bus.stack_err), 32'h1);
    idle();
    check("udf_err_clr", 32'(bus.stack_err), 32'h0);
    check("udf_next_pc", 32'(bus.pc), 32'h01);
    jump(8'hFF);
    idle();
    check("wrap_pc", 32'(bus.pc), 32'h00);
    check("wrap_err", 32'(bus.stack_err), 32'h0);

    // Call and ret together leave occupancy alone
    do_call(8'h30);
    step(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1);
    check("both_pc", 32'(bus.pc), 32'h31);
    check("both_err", 32'(bus.stack_err), 32'h1);
    check("both_empty", 32'(bus.stack_empty), 32'h0);
    do_ret();
    check("both_ret_pc", 32'(bus.pc), 32'h01);
    check("both_ret_empty", 32'(bus.stack_empty), 32'h1);

    // Stall masks a call
    step(1'b0, 1'b1, 1'b0, 8'h50, 1'b1, 1'b0);
    check("stall_call_pc", 32'(bus.pc), 32'h01);
    check("stall_call_empty", 32'(bus.stack_empty), 32'h1);

    // Reset with stall and a partly filled stack
    for (int i = 0; i < 4; i++) do_call(8'(8'h40 + 8'h10 * i));
    check("pre_rst_empty", 32'(bus.stack_empty), 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("mid_rst_pc", 32'(bus.pc), 32'h0);
    check("mid_rst_empty", 32'(bus.stack_empty), 32'h1);
    check("mid_rst_err", 32'(bus.stack_err), 32'h0);
    idle();
    check("post_rst_pc", 32'(bus.pc), 32'h1);
    do_ret();
    check("post_rst_ret_err", 32'(bus.stack_err), 32'h1);
    check("post_rst_ret_pc", 32'(bus.pc), 32'h2);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 8: program counter and jump address width (instruction memory of 2^PC_W words).
REQ-002 Parameter STACK_DEPTH, default 8: return-address stack entries, power of two, >= 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and stack unchanged this cycle.
REQ-006 jump_enable  input  1  taken-branch indication from the jump-condition logic.
REQ-007 jump_addr  input  PC_W  branch, call or jump target address.
REQ-008 call  input  1  call instruction: push return address, load jump_addr.
REQ-009 ret  input  1  return instruction: pop stack into PC.
REQ-010 pc  output  PC_W  current instruction address, registered.
REQ-011 stack_empty  output  1  stack holds zero entries, registered.
REQ-012 stack_full  output  1  stack holds STACK_DEPTH entries, registered.
REQ-013 stack_err  output  1  one-cycle pulse on an illegal stack operation, registered.

Function
REQ-014 All outputs are registered; a decision sampled at rising edge N is visible on pc at edge N (one-cycle latency, no combinational input-to-output path).
REQ-015 Per-edge priority: reset > stall > (call and ret together) > ret > call > jump_enable > increment.
REQ-016 stall=1: pc, stack contents and pointer unchanged; stack_err=0; all other inputs ignored.
REQ-017 Increment: pc <= pc+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0 without error.
REQ-018 jump_enable=1, call=0, ret=0: pc <= jump_addr; stack unchanged.
REQ-019 call=1, stack not full: push (pc+1) mod 2^PC_W; pc <= jump_addr; jump_enable ignored.
REQ-020 call=1, stack full: stack unchanged; pc <= pc+1; stack_err=1 for one cycle.
REQ-021 ret=1, stack not empty: pc <= top entry; pop; jump_enable ignored.
REQ-022 ret=1, stack empty: stack unchanged; pc <= pc+1; stack_err=1 for one cycle.
REQ-023 call=1 and ret=1 together: stack unchanged; pc <= pc+1; stack_err=1 for one cycle.
REQ-024 stack_empty and stack_full reflect occupancy after the same edge that updates pc.
REQ-025 Occupancy counter is log2(STACK_DEPTH)+1 bits wide; never exceeds STACK_DEPTH and never underflows.
REQ-026 stack_err is 0 on every edge not covered by REQ-020, REQ-022 or REQ-023.

Reset
REQ-027 reset=1 at a rising edge: pc=0, occupancy=0, stack_empty=1, stack_full=0, stack_err=0, overriding stall and all other inputs.
REQ-028 Reset mid-operation, including with a full stack, discards all entries; stack storage contents are not required to clear.
REQ-029 On the first edge after reset deasserts, normal priority applies (pc becomes 1 when no other input is active).

Structure
REQ-030 PC_W and STACK_DEPTH defaults, plus a next-PC select enumeration (HOLD, INC, JUMP, CALL, RET), reside in shared package cpu_pkg.
REQ-031 The LIFO is sub-module ret_stack, with push, pop, wdata, rdata, empty, full; pc_unit owns priority and error decisions.

Verification
REQ-032 Reset, then 3 idle edges -> pc 0,1,2,3; stack_empty=1.
REQ-033 pc=0x10, jump_enable=1, jump_addr=0x40 -> pc=0x40; with stall=1 held instead -> pc stays 0x10.
REQ-034 pc=0x05, call to 0x80; then ret -> pc=0x80 then 0x06; stack_empty 0,1.
REQ-035 8 nested calls from pc=0x00 -> stack_full=1; 9th call -> stack_err pulse, pc=previous target+1; 8 rets return addresses in LIFO order.
REQ-036 ret on empty stack at pc=0xFF -> pc=0x00, stack_err=1 for exactly one cycle; call+ret together -> stack_err=1, occupancy unchanged.
REQ-037 reset asserted with stall=1 and 4 entries stacked -> pc=0, stack_empty=1, stack_err=0 on the next edge.
